in_dev_fifo: RTL and testbench
==============================

# in_dev_fifo

Buffered input-device port that sits directly upstream of the processor's input side. An external producer (switch bank, UART receiver) pushes bytes into an internal FIFO. The block presents them one at a time on `input_bus` using the processor's four-phase `in_dev_hs` / `in_dev_ack` handshake. `in_dev_hs` also drives interrupt source 3 of the interrupt system, so its level behaviour is specified exactly.

## Interface
- `DEPTH`, default 8: FIFO entries; must be a power of two, ≥ 2.
- `WIDTH`, default 8: data width; must match `input_bus`.
- `g_clk`  in  1  global clock; all state updates on the rising edge.
- `g_clr`  in  1  global reset; asynchronous, active-low.
- `wr_data`  in  WIDTH  producer byte.
- `wr_en`  in  1  producer push strobe; one byte per cycle while high.
- `full`  out  1  FIFO holds DEPTH entries.
- `count`  out  log2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky flag: a push was dropped.
- `ovf_clr`  in  1  synchronous clear of `overflow`.
- `input_bus`  out  WIDTH  byte offered to the processor.
- `in_dev_hs`  out  1  data-ready to the processor.
- `in_dev_ack`  in  1  processor has taken the byte.

## Operation
- **Reset (`g_clr`=0, asynchronous):**
  - FIFO empty, `count`=0, `full`=0, `overflow`=0.
  - `input_bus`=0, `in_dev_hs`=0, state IDLE.
- **Handshake FSM** (three states):
  - **IDLE** (`in_dev_hs`=0): if `count`≠0, latch the FIFO head into `input_bus` and go to OFFER. `in_dev_ack` is ignored in IDLE.
  - **OFFER** (`in_dev_hs`=1, `input_bus` held stable): when `in_dev_ack`=1, pop the head, drop `in_dev_hs`, go to WAIT_REL.
  - **WAIT_REL** (`in_dev_hs`=0): stay until `in_dev_ack`=0, then go to IDLE. A new offer cannot start until ack has been released.
- **Pop rule:** exactly one pop per handshake, on the OFFER→WAIT_REL transition.
- **Push rule:**
  - `wr_en`=1 and not full: write at the tail and increment `count`.
  - `wr_en`=1 and full with no pop in the same cycle: drop the byte, set `overflow`, leave `count` unchanged.
  - Push and pop in the same cycle: `count` unchanged. This is legal even when full, because the pop frees the slot and the push is accepted.
  - Push and pop in the same cycle with `count`=1: the popped byte is the old head; the new byte becomes the head.
- **Pointers:** read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. `full` and empty are derived from `count`, not from pointer equality.
- **Overflow flag:**
  - `ovf_clr` and a new overflow event in the same cycle: `overflow` stays set (set wins).
  - `overflow` never affects FIFO contents.
- **`input_bus` between offers:** after the pop, `input_bus` retains the last offered byte until the next IDLE→OFFER latch.

## Timing
- **Push to handshake:** push into an empty FIFO at edge n gives `count`=1 after edge n. `in_dev_hs`=1 and valid `input_bus` follow after edge n+1, so latency is two cycles from `wr_en` to `in_dev_hs`.
- **Ack response:** `in_dev_ack` sampled high at edge m gives `in_dev_hs`=0 and `count` decremented after edge m.
- **Back-to-back minimum:** one transfer per three cycles (OFFER, WAIT_REL, IDLE), assuming ack is held for one cycle and releases immediately.
- **Registered outputs:** all outputs are registered except `full`, which is decoded from the `count` register.
- **Reset mid-handshake:** state, FIFO and handshake return to reset values immediately. The processor sees `in_dev_hs` fall with no pop.

## Structure
- **Shared package `io_pkg`:**
  - Handshake state encoding localparams: IDLE=2'd0, OFFER=2'd1, WAIT_REL=2'd2.
  - Default `DEPTH`.
  - State encoding 2'd3 is unreachable and recovers to IDLE.
- **Sub-module `byte_fifo`:**
  - Storage array, pointers, `count`, `full`, overflow logic, and a combinational `head` output.
  - `in_dev_fifo` adds the handshake FSM and the `input_bus` register.
  - The output-side device controller will reuse `byte_fifo`.

## Test plan
- **Reset:** assert `g_clr` low mid-OFFER with `count`=3 → all outputs 0 immediately, no pop recorded.
- **Single transfer:** push 8'hA5 at cycle 0 → `in_dev_hs`=1 with `input_bus`=8'hA5 at cycle 2. Ack pulse at cycle 4 → `in_dev_hs`=0 and `count`=0 at cycle 5.
- **Ordering / wrap:** push 12 bytes 8'h01..8'h0C while acking continuously → processor receives 01..0C in order, pointers wrap, `overflow`=0.
- **Overflow:** push 9 bytes into DEPTH=8 with no ack → `full`=1, `count`=8, `overflow`=1, head still 8'h01. Then pulse `ovf_clr` → `overflow`=0.
- **Simultaneous push/pop at full:**
  - With `count`=8, push 8'hFF in the same cycle the ack is taken → `count` stays 8, `overflow` stays 0.
  - Last offered byte is 8'hFF after 8 more handshakes.
- **Held ack:** hold `in_dev_ack` high for 5 cycles with `count`=2 → only one pop occurs. The next offer starts one cycle after ack falls.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the processor I/O device ports.
// Handshake state encoding and default buffer geometry.
package io_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] OFFER    = 2'd1;
  localparam logic [1:0] WAIT_REL = 2'd2;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = IDLE,
    ST_OFFER    = OFFER,
    ST_WAIT_REL = WAIT_REL
  } hs_state_e;

endpackage

// File: rtl/in_dev_fifo_if.sv
// Processor-side four-phase handshake of the input device.
// The device is master; the processor input side is slave.
interface in_dev_fifo_if
  import io_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] input_bus;
  logic             in_dev_hs;
  logic             in_dev_ack;

  modport master (
    output input_bus,
    output in_dev_hs,
    input  in_dev_ack
  );

  modport slave (
    input  input_bus,
    input  in_dev_hs,
    output in_dev_ack
  );

endinterface

// File: rtl/byte_fifo.sv
// Circular byte buffer with occupancy count and sticky overflow.
// Shared by the input and output device controllers.
module byte_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             pop,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && (count != '0);
  // a same-cycle pop frees the slot, so a push at full is accepted
  assign do_push = wr_en && (!full || do_pop);
  assign drop    = wr_en && full && !do_pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow <= drop | (overflow & ~ovf_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/in_dev_fifo.sv
// Buffered input device: producer pushes bytes, processor
// takes them one at a time over a four-phase hs/ack handshake.
module in_dev_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             g_clk,
  input  logic             g_clr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  input  logic             ovf_clr,
  in_dev_fifo_if.master    dev
);

  hs_state_e        state;
  hs_state_e        state_nx;
  logic             pop;
  logic             latch;
  logic [WIDTH-1:0] head;

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk      (g_clk),
    .rst_n    (g_clr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .pop      (pop),
    .ovf_clr  (ovf_clr),
    .head     (head),
    .count    (count),
    .full     (full),
    .overflow (overflow)
  );

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    latch    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (count != '0) begin
          latch    = 1'b1;
          state_nx = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (dev.in_dev_ack) begin
          pop      = 1'b1;
          state_nx = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (!dev.in_dev_ack)
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // bus keeps the last offered byte until the next offer latches
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state         <= ST_IDLE;
      dev.in_dev_hs <= 1'b0;
      dev.input_bus <= '0;
    end else begin
      state         <= state_nx;
      dev.in_dev_hs <= state_nx == ST_OFFER;
      if (latch)
        dev.input_bus <= head;
    end
  end

endmodule

// File: tb/tb_in_dev_fifo.sv
// Bench for in_dev_fifo: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_in_dev_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             g_clk = 1'b0;
  logic             g_clr;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_en = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             full;
  logic             overflow;
  logic [CW-1:0]    count;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx [$];

  in_dev_fifo_if #(.WIDTH(WIDTH)) dev ();

  in_dev_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .g_clk    (g_clk),
    .g_clr    (g_clr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .dev      (dev)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // reference model: byte queue plus offer/release flags
  logic [7:0] mq [$];
  bit         m_ovf = 0;
  bit         m_hs = 0;
  bit         m_rel = 0;
  logic [7:0] m_bus = '0;
  int         n0;
  logic [7:0] h0;
  bit         m_pop;
  bit         m_set;

  always @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      mq.delete();
      m_ovf = 0;
      m_hs  = 0;
      m_rel = 0;
      m_bus = '0;
    end else begin
      n0    = mq.size();
      h0    = (n0 > 0) ? mq[0] : 8'h00;
      m_pop = m_hs && dev.in_dev_ack;
      m_set = 0;
      if (m_pop)
        void'(mq.pop_front());
      if (wr_en) begin
        if (n0 < DEPTH || m_pop)
          mq.push_back(wr_data);
        else
          m_set = 1;
      end
      m_ovf = m_set | (m_ovf & !ovf_clr);
      if (m_pop) begin
        m_hs  = 0;
        m_rel = 1;
      end else if (m_rel) begin
        if (!dev.in_dev_ack)
          m_rel = 0;
      end else if (!m_hs && n0 > 0) begin
        m_hs  = 1;
        m_bus = h0;
      end
    end
  end

  always @(negedge g_clk) begin
    if (g_clr === 1'b1) begin
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
      chk("m_hs", 32'(dev.in_dev_hs), 32'(m_hs));
      chk("m_bus", 32'(dev.input_bus), 32'(m_bus));
    end
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic serve(input int n, input int budget);
    for (int k = 0; k < budget && rx.size() < n; k++) begin
      step();
      if (dev.in_dev_hs)
        rx.push_back(dev.input_bus);
      dev.in_dev_ack = dev.in_dev_hs;
    end
    chk("serve_done", 32'(rx.size() >= n), 1);
    step();
    dev.in_dev_ack = 1'b0;
    step();
    step();
  endtask

  task automatic wait_hs(input string name);
    for (int k = 0; k < 10 && !dev.in_dev_hs; k++)
      step();
    chk(name, 32'(dev.in_dev_hs), 1);
  endtask

  initial begin
    dev.in_dev_ack = 1'b0;
    g_clr = 1'b1;
    #1 g_clr = 1'b0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_hs", 32'(dev.in_dev_hs), 0);
    chk("rst_bus", 32'(dev.input_bus), 0);
    step();
    step();
    g_clr = 1'b1;
    step();

    // single transfer
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    chk("t1_count1", 32'(count), 1);
    chk("t1_hs_lo", 32'(dev.in_dev_hs), 0);
    step();
    chk("t1_hs", 32'(dev.in_dev_hs), 1);
    chk("t1_bus", 32'(dev.input_bus), 32'h A5);
    step();
    dev.in_dev_ack = 1'b1;
    step();
    chk("t1_hs_drop", 32'(dev.in_dev_hs), 0);
    chk("t1_count0", 32'(count), 0);
    chk("t1_bus_hold", 32'(dev.input_bus), 32'h A5);
    dev.in_dev_ack = 1'b0;
    step();
    step();

    // ordering and pointer wrap
    rx.delete();
    for (int c = 0; c < 200 && rx.size() < 12; c++) begin
      if (c < 24) begin
        wr_en   = (c % 2) == 0;
        wr_data = 8'(c / 2 + 1);
      end else begin
        wr_en = 1'b0;
      end
      step();
      if (dev.in_dev_hs)
        rx.push_back(dev.input_bus);
      dev.in_dev_ack = dev.in_dev_hs;
    end
    wr_en = 1'b0;
    step();
    dev.in_dev_ack = 1'b0;
    step();
    step();
    chk("ord_size", 32'(rx.size()), 12);
    for (int i = 0; i < 12; i++)
      chk("ord_byte", 32'(rx[i]), 32'(i + 1));
    chk("ord_ovf", 32'(overflow), 0);
    chk("ord_count", 32'(count), 0);

    // overflow with no ack
    for (int i = 0; i < 9; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i + 1);
      step();
    end
    wr_en = 1'b0;
    chk("ovf_full", 32'(full), 1);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head", 32'(dev.input_bus), 32'h01);
    chk("ovf_hs", 32'(dev.in_dev_hs), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    // push and pop together while full
    dev.in_dev_ack = 1'b1;
    wr_en          = 1'b1;
    wr_data        = 8'hFF;
    step();
    wr_en          = 1'b0;
    dev.in_dev_ack = 1'b0;
    chk("pp_count", 32'(count), 8);
    chk("pp_ovf", 32'(overflow), 0);
    chk("pp_hs", 32'(dev.in_dev_hs), 0);
    step();
    rx.delete();
    serve(8, 100);
    chk("pp_first", 32'(rx[0]), 32'h02);
    chk("pp_last", 32'(rx[7]), 32'h FF);
    chk("pp_drained", 32'(count), 0);

    // held ack gives exactly one pop
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    step();
    wr_data = 8'hC3;
    step();
    wr_en = 1'b0;
    wait_hs("hold_hs_up");
    chk("hold_count2", 32'(count), 2);
    dev.in_dev_ack = 1'b1;
    repeat (5) step();
    chk("hold_count1", 32'(count), 1);
    chk("hold_hs_lo", 32'(dev.in_dev_hs), 0);
    dev.in_dev_ack = 1'b0;
    step();
    chk("hold_rel_hs", 32'(dev.in_dev_hs), 0);
    step();
    chk("hold_next_hs", 32'(dev.in_dev_hs), 1);
    chk("hold_next_bus", 32'(dev.input_bus), 32'h C3);
    rx.delete();
    serve(1, 20);
    chk("hold_drained", 32'(count), 0);

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      wr_en          = 1'($urandom_range(0, 1));
      wr_data        = 8'($urandom);
      ovf_clr        = $urandom_range(0, 15) == 0;
      dev.in_dev_ack = $urandom_range(0, 2) != 0;
      step();
    end
    wr_en          = 1'b0;
    ovf_clr        = 1'b0;
    dev.in_dev_ack = 1'b0;
    step();
    step();

    // reset in the middle of an offer
    g_clr = 1'b0;
    step();
    g_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h11 * (i + 1));
      step();
    end
    wr_en = 1'b0;
    wait_hs("mid_hs_up");
    chk("mid_count3", 32'(count), 3);
    #2;
    g_clr = 1'b0;
    #1;
    chk("mid_count", 32'(count), 0);
    chk("mid_full", 32'(full), 0);
    chk("mid_ovf", 32'(overflow), 0);
    chk("mid_hs", 32'(dev.in_dev_hs), 0);
    chk("mid_bus", 32'(dev.input_bus), 0);
    step();
    g_clr = 1'b1;
    step();
    step();
    chk("mid_after_count", 32'(count), 0);
    chk("mid_after_hs", 32'(dev.in_dev_hs), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
